// File: rtl/seq_divider8.sv
// Sequential restoring shift-subtract divider: one trial subtract per cycle, WIDTH iterations.
// Optional feature macro SIGNED_DIV_EN: two's-complement operands, truncating division.
module seq_divider8 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, next_state;

   logic [WIDTH-1:0] rem_acc, rem_acc_nxt;
   logic [WIDTH-1:0] quo_acc, quo_acc_nxt;
   logic [WIDTH-1:0] dsr, dsr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
   logic             busy_nxt, done_nxt, div_by_zero_nxt;

   logic [WIDTH-1:0] dividend_mag, divisor_mag;
   logic [WIDTH-1:0] rem_step, quo_step;
   logic [WIDTH-1:0] rem_final, quo_final;
   logic [WIDTH:0]   trial;
   logic [WIDTH+1:0] diff;
   logic             borrow;
   logic             divisor_zero;

   assign divisor_zero = (divisor == '0);

`ifdef SIGNED_DIV_EN
   logic neg_quo, neg_quo_nxt;
   logic neg_rem, neg_rem_nxt;

   // Iterate on magnitudes; signs are reapplied on the final step.
   always_comb begin
      dividend_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
      divisor_mag  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
      quo_final    = neg_quo ? (~quo_step + WIDTH'(1)) : quo_step;
      rem_final    = neg_rem ? (~rem_step + WIDTH'(1)) : rem_step;
   end
`else
   always_comb begin
      dividend_mag = dividend;
      divisor_mag  = divisor;
      quo_final    = quo_step;
      rem_final    = rem_step;
   end
`endif

   // One restoring step: trial subtract of the divisor from the shifted partial remainder.
   always_comb begin
      trial    = {rem_acc, quo_acc[WIDTH-1]};
      diff     = {1'b0, trial} - {2'b00, dsr};
      borrow   = diff[WIDTH+1];
      rem_step = borrow ? trial[WIDTH-1:0] : WIDTH'(diff);
      quo_step = {quo_acc[WIDTH-2:0], ~borrow};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; a zero divisor skips iteration entirely.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = divisor_zero ? DONE : ITER;
         ITER:    if (cnt == LAST_CNT) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      rem_acc_nxt     = rem_acc;
      quo_acc_nxt     = quo_acc;
      dsr_nxt         = dsr;
      cnt_nxt         = cnt;
      quotient_nxt    = quotient;
      remainder_nxt   = remainder;
      div_by_zero_nxt = div_by_zero;
`ifdef SIGNED_DIV_EN
      neg_quo_nxt     = neg_quo;
      neg_rem_nxt     = neg_rem;
`endif
      busy_nxt        = (next_state == ITER);
      done_nxt        = (next_state == DONE);
      case (state)
         IDLE: begin
            if (start) begin
               dsr_nxt         = divisor_mag;
               quo_acc_nxt     = dividend_mag;
               rem_acc_nxt     = '0;
               cnt_nxt         = '0;
               div_by_zero_nxt = 1'b0;
`ifdef SIGNED_DIV_EN
               neg_quo_nxt     = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               neg_rem_nxt     = dividend[WIDTH-1];
`endif
               if (divisor_zero) begin
                  quotient_nxt    = '1;
                  remainder_nxt   = dividend;
                  div_by_zero_nxt = 1'b1;
               end
            end
         end
         ITER: begin
            rem_acc_nxt = rem_step;
            quo_acc_nxt = quo_step;
            cnt_nxt     = cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
               quotient_nxt  = quo_final;
               remainder_nxt = rem_final;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_acc     <= '0;
         quo_acc     <= '0;
         dsr         <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_quo     <= 1'b0;
         neg_rem     <= 1'b0;
`endif
      end else begin
         rem_acc     <= rem_acc_nxt;
         quo_acc     <= quo_acc_nxt;
         dsr         <= dsr_nxt;
         cnt         <= cnt_nxt;
         quotient    <= quotient_nxt;
         remainder   <= remainder_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         div_by_zero <= div_by_zero_nxt;
`ifdef SIGNED_DIV_EN
         neg_quo     <= neg_quo_nxt;
         neg_rem     <= neg_rem_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_seq_divider8.sv
// Directed testbench for seq_divider8: latency, results, divide-by-zero, ignored Start, reset abort, back-to-back.
module tb_seq_divider8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seq_divider8 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   // Pulse Start for one edge, then count edges until Done (lat=1 is the sample after the accepting edge).
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         output int busy_cnt, output int lat, output bit timed_out);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      timed_out = !done;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 8'd0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, expected all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      int bc, lat;
      bit to;
`ifdef SIGNED_DIV_EN
      logic [7:0] exp_q = 8'hF8;
      logic [7:0] exp_r = 8'h00;
`else
      logic [7:0] exp_q = 8'h1C;
      logic [7:0] exp_r = 8'h04;
`endif
      run_op(8'd200, 8'd7, bc, lat, to);
      vectors++;
      if (to) begin
         miscompares++;
         $display("FAIL basic_timeout: Done not seen within %0d cycles", lat);
      end
      vectors++;
      if (lat != 9) begin
         miscompares++;
         $display("FAIL basic_latency: got %0d edges, expected 9", lat);
      end
      vectors++;
      if (bc != 8) begin
         miscompares++;
         $display("FAIL basic_busy_cycles: got %0d, expected 8", bc);
      end
      vectors++;
      if (quotient !== exp_q || remainder !== exp_r || div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_result: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=0",
                  quotient, remainder, div_by_zero, exp_q, exp_r);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || quotient !== exp_q) begin
         miscompares++;
         $display("FAIL basic_done_pulse: got done=%b q=%h, expected done=0 q=%h", done, quotient, exp_q);
      end
   endtask

   task automatic test_corners();
      int bc, lat;
      bit to;
      run_op(8'd255, 8'd255, bc, lat, to);
      vectors++;
      if (to || quotient !== 8'd1 || remainder !== 8'd0) begin
         miscompares++;
         $display("FAIL equal_operands: got q=%h r=%h timeout=%b, expected q=01 r=00", quotient, remainder, to);
      end
      run_op(8'd5, 8'd9, bc, lat, to);
      vectors++;
      if (to || quotient !== 8'd0 || remainder !== 8'd5) begin
         miscompares++;
         $display("FAIL small_dividend: got q=%h r=%h timeout=%b, expected q=00 r=05", quotient, remainder, to);
      end
   endtask

   task automatic test_div_zero();
      int bc, lat;
      bit to;
      run_op(8'd13, 8'd0, bc, lat, to);
      vectors++;
      if (to || lat != 1) begin
         miscompares++;
         $display("FAIL dbz_latency: got %0d edges timeout=%b, expected 1", lat, to);
      end
      vectors++;
      if (bc != 0) begin
         miscompares++;
         $display("FAIL dbz_busy: got %0d busy cycles, expected 0", bc);
      end
      vectors++;
      if (quotient !== 8'hFF || remainder !== 8'd13 || div_by_zero !== 1'b1) begin
         miscompares++;
         $display("FAIL dbz_result: got q=%h r=%h dbz=%b, expected q=ff r=0d dbz=1",
                  quotient, remainder, div_by_zero);
      end
      run_op(8'd20, 8'd4, bc, lat, to);
      vectors++;
      if (to || quotient !== 8'd5 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL dbz_clear: got q=%h r=%h dbz=%b, expected q=05 r=00 dbz=0",
                  quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd3;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      dividend = 8'd0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 5;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL ignore_busy: got busy=%b after E4, expected 1", busy);
      end
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (lat != 9) begin
         miscompares++;
         $display("FAIL ignore_latency: got %0d edges, expected 9", lat);
      end
      vectors++;
      if (quotient !== 8'd33 || remainder !== 8'd1) begin
         miscompares++;
         $display("FAIL ignore_result: got q=%h r=%h, expected q=21 r=01", quotient, remainder);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore_no_restart: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid();
      bit saw_activity;
      @(negedge clk);
      dividend = 8'd50;
      divisor  = 8'd6;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset_abort_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, expected all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      @(negedge clk);
      rst = 1'b0;
      saw_activity = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done || busy) saw_activity = 1'b1;
      end
      vectors++;
      if (saw_activity) begin
         miscompares++;
         $display("FAIL reset_abort_done: got busy/done activity after abort, expected none");
      end
   endtask

   task automatic test_back_to_back();
      int n_done;
      int waited;
      @(negedge clk);
      dividend = 8'd50;
      divisor  = 8'd6;
      start    = 1'b1;
      n_done   = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            vectors++;
            if ((i % 10) != 9 || quotient !== 8'd8 || remainder !== 8'd2) begin
               miscompares++;
               $display("FAIL b2b_result: got done at edge %0d q=%h r=%h, expected edge%%10==9 q=08 r=02",
                        i, quotient, remainder);
            end
         end
      end
      start = 1'b0;
      vectors++;
      if (n_done != 3) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d completions, expected 3", n_done);
      end
      waited = 0;
      while ((busy || done) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_drain: got busy=%b done=%b after %0d cycles, expected idle", busy, done, waited);
      end
   endtask

`ifdef SIGNED_DIV_EN
   task automatic test_signed();
      int bc, lat;
      bit to;
      run_op(8'h9C, 8'h07, bc, lat, to);
      vectors++;
      if (to || lat != 9 || quotient !== 8'hF2 || remainder !== 8'hFE) begin
         miscompares++;
         $display("FAIL signed_neg_dividend: got q=%h r=%h lat=%0d, expected q=f2 r=fe lat=9",
                  quotient, remainder, lat);
      end
      run_op(8'h64, 8'hF9, bc, lat, to);
      vectors++;
      if (to || quotient !== 8'hF2 || remainder !== 8'h02) begin
         miscompares++;
         $display("FAIL signed_neg_divisor: got q=%h r=%h, expected q=f2 r=02", quotient, remainder);
      end
      run_op(8'h80, 8'hFF, bc, lat, to);
      vectors++;
      if (to || quotient !== 8'h80 || remainder !== 8'h00 || div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL signed_wrap: got q=%h r=%h dbz=%b, expected q=80 r=00 dbz=0",
                  quotient, remainder, div_by_zero);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
`ifdef SIGNED_DIV_EN
      test_signed();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
